ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard_pkg.sv | 46 ++++
 rtl/ps2_scancode_map.sv | 80 ++++++++
 rtl/ps2_keyboard.sv | 167 ++++++++++++++++
 tb/tb_ps2_keyboard.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and scancode mapper.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ps2_keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Scancode set 2 prefix and modifier bytes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Hack special-key codes
  localparam logic [7:0] KEY_ENTER  = 8'd128;
  localparam logic [7:0] KEY_BKSP   = 8'd129;
  localparam logic [7:0] KEY_LEFT   = 8'd130;
  localparam logic [7:0] KEY_UP     = 8'd131;
  localparam logic [7:0] KEY_RIGHT  = 8'd132;
  localparam logic [7:0] KEY_DOWN   = 8'd133;
  localparam logic [7:0] KEY_HOME   = 8'd134;
  localparam logic [7:0] KEY_END    = 8'd135;
  localparam logic [7:0] KEY_PGUP   = 8'd136;
  localparam logic [7:0] KEY_PGDN   = 8'd137;
  localparam logic [7:0] KEY_INSERT = 8'd138;
  localparam logic [7:0] KEY_DELETE = 8'd139;
  localparam logic [7:0] KEY_ESC    = 8'd140;
  localparam logic [7:0] KEY_F1     = 8'd141;
  localparam logic [7:0] KEY_F2     = 8'd142;
  localparam logic [7:0] KEY_F3     = 8'd143;
  localparam logic [7:0] KEY_F4     = 8'd144;
  localparam logic [7:0] KEY_F5     = 8'd145;
  localparam logic [7:0] KEY_F6     = 8'd146;
  localparam logic [7:0] KEY_F7     = 8'd147;
  localparam logic [7:0] KEY_F8     = 8'd148;
  localparam logic [7:0] KEY_F9     = 8'd149;
  localparam logic [7:0] KEY_F10    = 8'd150;
  localparam logic [7:0] KEY_F11    = 8'd151;
  localparam logic [7:0] KEY_F12    = 8'd152;

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational translation of a set-2 scancode (plus ext/shift context) to a Hack key code.
// Latency: zero cycles, purely combinational.
// Backpressure: none; unmapped scancodes yield 0.
module ps2_scancode_map
  import ps2_keyboard_pkg::*;
(
  input  logic [7:0]  scancode,
  input  logic        ext,
  input  logic        shift,
  output logic [15:0] code
);

  logic [7:0] c;

  // Lookup table: extended keys first, otherwise letters/digits/symbols/specials
  always_comb begin
    c = 8'd0;
    if (ext) begin
      case (scancode)
        8'h6B: c = KEY_LEFT;
        8'h75: c = KEY_UP;
        8'h74: c = KEY_RIGHT;
        8'h72: c = KEY_DOWN;
        8'h6C: c = KEY_HOME;
        8'h69: c = KEY_END;
        8'h7D: c = KEY_PGUP;
        8'h7A: c = KEY_PGDN;
        8'h70: c = KEY_INSERT;
        8'h71: c = KEY_DELETE;
        8'h5A: c = KEY_ENTER;
        default: c = 8'd0;
      endcase
    end else begin
      case (scancode)
        // letters are always uppercase
        8'h1C: c = 8'd65;  8'h32: c = 8'd66;  8'h21: c = 8'd67;  8'h23: c = 8'd68;
        8'h24: c = 8'd69;  8'h2B: c = 8'd70;  8'h34: c = 8'd71;  8'h33: c = 8'd72;
        8'h43: c = 8'd73;  8'h3B: c = 8'd74;  8'h42: c = 8'd75;  8'h4B: c = 8'd76;
        8'h3A: c = 8'd77;  8'h31: c = 8'd78;  8'h44: c = 8'd79;  8'h4D: c = 8'd80;
        8'h15: c = 8'd81;  8'h2D: c = 8'd82;  8'h1B: c = 8'd83;  8'h2C: c = 8'd84;
        8'h3C: c = 8'd85;  8'h2A: c = 8'd86;  8'h1D: c = 8'd87;  8'h22: c = 8'd88;
        8'h35: c = 8'd89;  8'h1A: c = 8'd90;
        // digits row
        8'h16: c = shift ? 8'd33 : 8'd49;
        8'h1E: c = shift ? 8'd64 : 8'd50;
        8'h26: c = shift ? 8'd35 : 8'd51;
        8'h25: c = shift ? 8'd36 : 8'd52;
        8'h2E: c = shift ? 8'd37 : 8'd53;
        8'h36: c = shift ? 8'd94 : 8'd54;
        8'h3D: c = shift ? 8'd38 : 8'd55;
        8'h3E: c = shift ? 8'd42 : 8'd56;
        8'h46: c = shift ? 8'd40 : 8'd57;
        8'h45: c = shift ? 8'd41 : 8'd48;
        // symbols
        8'h0E: c = shift ? 8'd126 : 8'd96;
        8'h4E: c = shift ? 8'd95  : 8'd45;
        8'h55: c = shift ? 8'd43  : 8'd61;
        8'h54: c = shift ? 8'd123 : 8'd91;
        8'h5B: c = shift ? 8'd125 : 8'd93;
        8'h5D: c = shift ? 8'd124 : 8'd92;
        8'h4C: c = shift ? 8'd58  : 8'd59;
        8'h52: c = shift ? 8'd34  : 8'd39;
        8'h41: c = shift ? 8'd60  : 8'd44;
        8'h49: c = shift ? 8'd62  : 8'd46;
        8'h4A: c = shift ? 8'd63  : 8'd47;
        // specials
        8'h29: c = 8'd32;
        8'h5A: c = KEY_ENTER;
        8'h66: c = KEY_BKSP;
        8'h76: c = KEY_ESC;
        8'h05: c = KEY_F1;   8'h06: c = KEY_F2;   8'h04: c = KEY_F3;   8'h0C: c = KEY_F4;
        8'h03: c = KEY_F5;   8'h0B: c = KEY_F6;   8'h83: c = KEY_F7;   8'h0A: c = KEY_F8;
        8'h01: c = KEY_F9;   8'h09: c = KEY_F10;  8'h78: c = KEY_F11;  8'h07: c = KEY_F12;
        default: c = 8'd0;
      endcase
    end
    code = {8'h00, c};
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: sync + glitch filter, frame FSM, make/break decode to a held Hack key code.
// Latency: byte_done one cycle after the stop edge, kb_out one cycle after byte_done.
// Backpressure: none; the keyboard cannot be stalled, bad or stalled frames are dropped with rx_error.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kb_out,
  output logic        rx_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, fall;
  logic [FW-1:0] filt_cnt;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo_cnt;
  logic          byte_done, frame_bad;
  logic          ext, brk, lshift, rshift, shift;
  logic [15:0]   map_code;

  // Two-flop synchronizers; idle PS/2 lines are high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;  clk_s2 <= clk_s1;
      dat_s1 <= ps2_data; dat_s2 <= dat_s1;
    end
  end

  // Clock filter: follow the line only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_cnt <= '0;
      filt_clk <= 1'b1;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
          fall     <= ~clk_s2;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Frame FSM: start, 8 data LSB first, odd parity, stop; timeout abandons a stalled frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tmo_cnt   <= '0;
      byte_done <= 1'b0;
      frame_bad <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_bad <= 1'b0;
      rx_error  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              rx_error <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && (^{shreg, par})) begin
              byte_done <= 1'b1;
            end else begin
              frame_bad <= 1'b1;
              rx_error  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state    <= IDLE;
          rx_error <= 1'b1;
          tmo_cnt  <= '0;
          bit_cnt  <= '0;
          shreg    <= '0;
          par      <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

  assign shift = lshift | rshift;

  ps2_scancode_map u_map (
    .scancode (shreg),
    .ext      (ext),
    .shift    (shift),
    .code     (map_code)
  );

  // Decoder: prefix flags, shift tracking, and held-key register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kb_out <= '0;
      ext    <= 1'b0;
      brk    <= 1'b0;
      lshift <= 1'b0;
      rshift <= 1'b0;
    end else if (frame_bad) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_done) begin
      if (shreg == SC_EXT) begin
        ext <= 1'b1;
      end else if (shreg == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (!ext && shreg == SC_LSHIFT) begin
          lshift <= ~brk;
        end else if (!ext && shreg == SC_RSHIFT) begin
          rshift <= ~brk;
        end else if (map_code != 16'd0) begin
          if (!brk) kb_out <= map_code;
          else if (kb_out == map_code) kb_out <= 16'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: make/break, shift, extended keys, bad frames, timeout, glitch, reset.
// Latency: each frame is checked after its stop bit has fully settled.
// Backpressure: none; the bench plays the keyboard and only observes.
module tb_ps2_keyboard;

  localparam int HP   = 30;   // PS/2 half period in clk cycles
  localparam int TOUT = 400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] kb_out;
  logic        rx_error;

  int checks = 0;
  int passed = 0;
  int err_cnt = 0;
  int err_base;

  ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb_out   (kb_out),
    .rx_error (rx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_error === 1'b1) err_cnt++;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clks(HP);
    ps2_clk = 1'b0;
    wait_clks(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip, input logic stopv);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ flip);
    ps2_bit(stopv);
    ps2_data = 1'b1;
    wait_clks(HP);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b1);
  endtask

  initial begin
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset_n  = 1'b0;
    wait_clks(5);
    check("reset_kb_out", kb_out, 16'd0);
    check("reset_rx_error", {15'd0, rx_error}, 16'd0);
    reset_n = 1'b1;
    wait_clks(20);

    // Plain make and break
    send(8'h1C);
    check("make_A", kb_out, 16'd65);
    send(8'hF0); send(8'h1C);
    check("break_A", kb_out, 16'd0);

    // Shift handling
    send(8'h12); send(8'h16);
    check("shift_1", kb_out, 16'd33);
    send(8'hF0); send(8'h12); send(8'h16);
    check("unshift_1", kb_out, 16'd49);

    // Extended keys
    send(8'hE0); send(8'h75);
    check("ext_up", kb_out, 16'd131);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_up_break", kb_out, 16'd0);
    send(8'h5A);
    check("enter", kb_out, 16'd128);

    // Unmapped scancode leaves kb_out alone
    send(8'h77);
    check("unmapped", kb_out, 16'd128);

    // Bad parity and bad stop
    err_base = err_cnt;
    send_byte(8'h1C, 1'b1, 1'b1);
    check("parity_err_cnt", 16'(err_cnt - err_base), 16'd1);
    check("parity_kb_out", kb_out, 16'd128);
    err_base = err_cnt;
    send_byte(8'h1C, 1'b0, 1'b0);
    check("stop_err_cnt", 16'(err_cnt - err_base), 16'd1);
    check("stop_kb_out", kb_out, 16'd128);

    // Break prefix cleared by a bad frame: 5A afterwards is a make
    send(8'hF0);
    send_byte(8'h33, 1'b1, 1'b1);
    send(8'h5A);
    check("brk_cleared", kb_out, 16'd128);

    // Timeout after start + 4 data bits
    err_base = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_clks(TOUT + 200);
    check("timeout_err_cnt", 16'(err_cnt - err_base), 16'd1);
    send(8'h1C);
    check("after_timeout", kb_out, 16'd65);
    check("after_timeout_err", 16'(err_cnt - err_base), 16'd1);

    // 3-cycle glitch with data low must not start a frame
    send(8'h5A);
    err_base = err_cnt;
    ps2_data = 1'b0;
    wait_clks(5);
    ps2_clk = 1'b0;
    wait_clks(3);
    ps2_clk = 1'b1;
    wait_clks(5);
    ps2_data = 1'b1;
    wait_clks(HP);
    send(8'h1C);
    check("glitch_kb_out", kb_out, 16'd65);
    check("glitch_err_cnt", 16'(err_cnt - err_base), 16'd0);

    // Reset in the middle of a frame
    err_base = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    reset_n = 1'b0;
    wait_clks(5);
    ps2_data = 1'b1;
    check("midreset_kb_out", kb_out, 16'd0);
    reset_n = 1'b1;
    wait_clks(TOUT + 100);
    check("midreset_err_cnt", 16'(err_cnt - err_base), 16'd0);
    send(8'h1C);
    check("post_reset_make", kb_out, 16'd65);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
